// File: rtl/tune_sequencer_if.sv
// Signal bundle between the tune sequencer, its button pulses, the note ROM and the tone generator.
// master: the sequencer side; slave: the surrounding environment.
interface tune_sequencer_if;
    logic       toggle;
    logic       stop;
    logic       loop;
    logic [7:0] rom_addr;
    logic [7:0] rom_note;
    logic [5:0] note_out;
    logic       tone_en;
    logic       playing;
    logic       paused;
    logic       done;

    modport master (
        input  toggle, stop, loop, rom_note,
        output rom_addr, note_out, tone_en, playing, paused, done
    );

    modport slave (
        output toggle, stop, loop, rom_note,
        input  rom_addr, note_out, tone_en, playing, paused, done
    );
endinterface

// File: rtl/tune_sequencer.sv
// Steps a registered note ROM through a song slot by slot, with start/pause/resume/stop control.
// Song repeat on `loop` is compiled in only when TUNE_SEQ_LOOP_EN is defined.
module tune_sequencer #(
    parameter int unsigned SLOT_CYC = 4194304,
    parameter int unsigned GAP_CYC  = 262144,
    parameter int unsigned SONG_LEN = 241
) (
    input  logic                    clk,
    input  logic                    rst,
    tune_sequencer_if.master        bus
);
    localparam int unsigned     CntW     = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CntW-1:0] SlotLast = CntW'(SLOT_CYC - 1);
    localparam logic [CntW-1:0] GapCnt   = CntW'(GAP_CYC);
    localparam logic [7:0]      AddrLast = 8'(SONG_LEN - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StPause} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [5:0]      note_q, note_d;
    logic            pend_q, pend_d;
    logic            tone_q, tone_d;
    logic            done_c;
    logic            loop_c;

    logic unused_rom_hi;
    assign unused_rom_hi = ^bus.rom_note[7:6];

`ifdef TUNE_SEQ_LOOP_EN
    assign loop_c = bus.loop;
`else
    logic unused_loop;
    assign unused_loop = bus.loop;
    assign loop_c      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        note_d  = note_q;
        pend_d  = pend_q;
        done_c  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.toggle && !bus.stop) begin
                    state_d = StFetch;
                    addr_d  = '0;
                end
            end
            StFetch: begin
                state_d = StLoad;
                if (bus.toggle) pend_d = 1'b1;
            end
            StLoad: begin
                state_d = StPlay;
                note_d  = bus.rom_note[5:0];
                cnt_d   = '0;
                if (bus.toggle) pend_d = 1'b1;
            end
            StPlay: begin
                // A pause request takes precedence over slot completion; the count stays put.
                if (pend_q || bus.toggle) begin
                    state_d = StPause;
                    pend_d  = 1'b0;
                end else if (cnt_q == SlotLast) begin
                    cnt_d = '0;
                    if (addr_q != AddrLast) begin
                        addr_d  = addr_q + 8'd1;
                        state_d = StFetch;
                    end else begin
                        done_c = 1'b1;
                        addr_d = '0;
                        if (loop_c) begin
                            state_d = StFetch;
                        end else begin
                            state_d = StIdle;
                            note_d  = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPause: begin
                if (bus.toggle) state_d = StPlay;
            end
            default: state_d = StIdle;
        endcase

        if (bus.stop && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            addr_d  = '0;
            note_d  = '0;
            pend_d  = 1'b0;
            done_c  = 1'b0;
        end

        // Gate on the next state too, so the tone drops in the very cycle PLAY is left.
        tone_d = (state_q == StPlay) && (state_d == StPlay) && (note_q != 6'd0) &&
                 (cnt_q >= GapCnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            note_q  <= '0;
            pend_q  <= 1'b0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            pend_q  <= pend_d;
            tone_q  <= tone_d;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.note_out = note_q;
    assign bus.tone_en  = tone_q;
    assign bus.playing  = (state_q == StFetch) || (state_q == StLoad) || (state_q == StPlay);
    assign bus.paused   = (state_q == StPause);
    assign bus.done     = done_c;
endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer: slot-position model checked every cycle, plus literal timing pins.
module tb_tune_sequencer;
    localparam int SLOT = 16;
    localparam int GAP  = 4;
    localparam int LEN  = 4;
`ifdef TUNE_SEQ_LOOP_EN
    localparam bit LoopBuilt = 1'b1;
`else
    localparam bit LoopBuilt = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    tune_sequencer_if bus ();

    tune_sequencer #(
        .SLOT_CYC (SLOT),
        .GAP_CYC  (GAP),
        .SONG_LEN (LEN)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Upper bits of entry 2 are junk that must be ignored (0x5B -> 27).
    logic [7:0] rom_tbl [4] = '{8'd25, 8'd0, 8'h5B, 8'd30};
    always_ff @(posedge clk) bus.rom_note <= rom_tbl[bus.rom_addr[1:0]];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: song position as m_pos within a slot (0 fetch, 1 load, 2.. play count+2).
    bit m_on, m_hold, m_pend, m_tone;
    int m_pos, m_addr, m_note;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_in_play();
        return m_on && !m_hold && (m_pos >= 2);
    endfunction

    task automatic model_step();
        bit tone_pre;
        tone_pre = m_in_play() && (m_note != 0) && (m_pos - 2 >= GAP);
        if (rst) begin
            m_on = 0; m_hold = 0; m_pend = 0; m_pos = 0; m_addr = 0; m_note = 0;
            m_tone = 0;
            return;
        end
        if (!m_on) begin
            if (bus.toggle && !bus.stop) begin
                m_on = 1; m_pos = 0; m_addr = 0;
            end
        end else if (bus.stop) begin
            m_on = 0; m_hold = 0; m_pend = 0; m_pos = 0; m_addr = 0; m_note = 0;
        end else if (m_hold) begin
            if (bus.toggle) m_hold = 0;
        end else if (m_pos < 2) begin
            if (bus.toggle) m_pend = 1;
            if (m_pos == 1) m_note = rom_tbl[m_addr] & 8'h3F;
            m_pos++;
        end else if (m_pend || bus.toggle) begin
            m_hold = 1; m_pend = 0;
        end else if (m_pos == SLOT + 1) begin
            m_pos = 0;
            if (m_addr == LEN - 1) begin
                m_addr = 0;
                if (!(LoopBuilt && bus.loop)) begin
                    m_on = 0; m_note = 0;
                end
            end else begin
                m_addr++;
            end
        end else begin
            m_pos++;
        end
        m_tone = tone_pre && m_in_play();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
                check("note_out", 32'(bus.note_out), 32'(m_note));
                check("tone_en", 32'(bus.tone_en), 32'(m_tone));
                check("playing", 32'(bus.playing), 32'(m_on && !m_hold));
                check("paused", 32'(bus.paused), 32'(m_hold));
                check("done", 32'(bus.done),
                      32'(!rst && m_in_play() && m_pos == SLOT + 1 && m_addr == LEN - 1 &&
                          !m_pend && !bus.toggle && !bus.stop));
            end
        end
    end

    task automatic tick(input bit t, input bit s);
        bus.toggle = t;
        bus.stop   = s;
        @(posedge clk);
        cyc++;
        model_step();
        #2;
        bus.toggle = 1'b0;
        bus.stop   = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick(1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.toggle = 1'b0;
        bus.stop   = 1'b0;
        bus.loop   = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        chk_en = 1'b1;
        check("pin_rst_addr", 32'(bus.rom_addr), 32'd0);
        check("pin_rst_note", 32'(bus.note_out), 32'd0);
        check("pin_rst_playing", 32'(bus.playing), 32'd0);
        check("pin_rst_paused", 32'(bus.paused), 32'd0);
        check("pin_rst_tone", 32'(bus.tone_en), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Start at cycle 10 and walk the first slots.
        run_to(10); tick(1'b1, 1'b0);
        check("pin_playing_11", 32'(bus.playing), 32'd1);
        run_to(12); check("pin_note_12", 32'(bus.note_out), 32'd0);
        run_to(13); check("pin_note_13", 32'(bus.note_out), 32'd25);
        run_to(17); check("pin_tone_17", 32'(bus.tone_en), 32'd0);
        run_to(18); check("pin_tone_18", 32'(bus.tone_en), 32'd1);
        run_to(28); check("pin_addr_28", 32'(bus.rom_addr), 32'd0);
        run_to(29); check("pin_addr_29", 32'(bus.rom_addr), 32'd1);
        check("pin_tone_fetch", 32'(bus.tone_en), 32'd0);
        run_to(40); check("pin_rest_note", 32'(bus.note_out), 32'd0);
        check("pin_rest_tone", 32'(bus.tone_en), 32'd0);
        check("pin_rest_playing", 32'(bus.playing), 32'd1);
        run_to(50); check("pin_note_masked", 32'(bus.note_out), 32'd27);
        run_to(81); check("pin_done_81", 32'(bus.done), 32'd0);
        run_to(82); check("pin_done_82", 32'(bus.done), 32'd1);
        run_to(83); check("pin_end_addr", 32'(bus.rom_addr), 32'd0);
`ifdef TUNE_SEQ_LOOP_EN
        check("pin_loop_playing", 32'(bus.playing), 32'd1);
        run_to(85); check("pin_loop_note", 32'(bus.note_out), 32'd25);
`else
        check("pin_end_playing", 32'(bus.playing), 32'd0);
        check("pin_end_note", 32'(bus.note_out), 32'd0);
`endif
        run_to(86); tick(1'b0, 1'b1);
        bus.loop = 1'b0;
        check("pin_stop_idle", 32'(bus.playing), 32'd0);

        // Pause at play count 10 for 50 cycles, then resume.
        run_to(100); tick(1'b1, 1'b0);
        run_to(113); tick(1'b1, 1'b0);
        check("pin_paused_114", 32'(bus.paused), 32'd1);
        check("pin_pause_playing", 32'(bus.playing), 32'd0);
        run_to(130); check("pin_pause_tone", 32'(bus.tone_en), 32'd0);
        run_to(163); tick(1'b1, 1'b0);
        check("pin_resume", 32'(bus.playing), 32'd1);
        run_to(169); check("pin_addr_169", 32'(bus.rom_addr), 32'd0);
        run_to(170); check("pin_addr_170", 32'(bus.rom_addr), 32'd1);

        // Stop and toggle together while playing.
        run_to(180); tick(1'b1, 1'b1);
        check("pin_stop_addr", 32'(bus.rom_addr), 32'd0);
        check("pin_stop_playing", 32'(bus.playing), 32'd0);
        check("pin_stop_paused", 32'(bus.paused), 32'd0);

        // Toggle during LOAD: one PLAY cycle, then PAUSE at count 0.
        run_to(190); tick(1'b1, 1'b0);
        run_to(192); tick(1'b1, 1'b0);
        check("pin_pend_play", 32'(bus.playing), 32'd1);
        run_to(194); check("pin_pend_paused", 32'(bus.paused), 32'd1);
        run_to(200); tick(1'b1, 1'b0);
        run_to(216); check("pin_pend_addr_216", 32'(bus.rom_addr), 32'd0);
        run_to(217); check("pin_pend_addr_217", 32'(bus.rom_addr), 32'd1);
        run_to(230);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/tune_sequencer.md
# tune_sequencer

Playback controller for the buzzer music path. Steps a registered note ROM through a song one time slot at a time and presents the current 6-bit fullnote to the octave/divider tone generator with a per-slot articulation gap. Handles start, pause, resume and stop from debounced push-button pulses, and optionally repeats the song. It sits between the button debouncers and the note ROM / tone generator, and replaces free-running address counters.

## Interface
Parameters:
- `SLOT_CYC`, default 4194304: clock cycles of the PLAY portion of one ROM slot; must be greater than `GAP_CYC`.
- `GAP_CYC`, default 262144: muted cycles at the start of each PLAY slot (articulation gap).
- `SONG_LEN`, default 241: number of ROM entries in the song; last address is `SONG_LEN-1`; range 1..256.

Ports:
- `clk` in 1: system clock (25 MHz PLL output).
- `rst` in 1: synchronous, active-high reset.
- `toggle` in 1: one-cycle pulse for start/pause/resume (debounced button-down).
- `stop` in 1: one-cycle pulse for abort to idle.
- `loop` in 1: repeat the song at its end; used only with `TUNE_SEQ_LOOP_EN`.
- `rom_addr` out 8: note ROM address.
- `rom_note` in 8: ROM data, valid one cycle after `rom_addr` changes (registered ROM); only bits [5:0] are used.
- `note_out` out 6: current fullnote; 0 = rest.
- `tone_en` out 1: gate for the buzzer toggle.
- `playing` out 1: high in FETCH, LOAD and PLAY.
- `paused` out 1: high in PAUSE.
- `done` out 1: one-cycle pulse at song end.

## Operation
- Reset (synchronous; highest priority):
  - state IDLE;
  - `rom_addr`, `note_out`, slot counter and pending flag all = 0;
  - `tone_en`, `playing`, `paused`, `done` all = 0.
- States and transitions:
  - IDLE: `toggle` → FETCH with `rom_addr=0`.
  - FETCH (1 cycle): address is stable while the ROM registers it → LOAD.
  - LOAD (1 cycle): `note_out <= rom_note[5:0]`, slot counter ← 0 → PLAY.
  - PLAY: slot counter increments each cycle. On the cycle where the counter equals `SLOT_CYC-1`:
    - if `rom_addr != SONG_LEN-1`: `rom_addr` ← `rom_addr+1` → FETCH;
    - otherwise: `done`=1 for that cycle, then either loop (`rom_addr` ← 0 → FETCH) or go IDLE (`rom_addr` ← 0, `note_out` ← 0).
  - PAUSE: slot counter, `rom_addr` and `note_out` are frozen; `toggle` → PLAY, resuming at the frozen count.
- `toggle` in PLAY → PAUSE the next cycle.
- `toggle` during FETCH or LOAD sets the pending flag. On entry to PLAY with pending set, go to PAUSE on the first PLAY cycle (slot count 0) and clear pending.
- `stop` in any non-IDLE state → IDLE, `rom_addr=0`, `note_out=0`, pending cleared, no `done`. `stop` in IDLE has no effect.
- If `stop` and `toggle` arrive in the same cycle, `stop` wins.
- `tone_en` = (state==PLAY) && (`note_out` != 0) && (slot counter ≥ `GAP_CYC`). Registered, so it follows the counter by one cycle.
- The slot counter width is $clog2(`SLOT_CYC`). The address increment never exceeds `SONG_LEN-1`, so there is no 8-bit wrap.

## Timing
- Slot period is exactly `SLOT_CYC+2` cycles: FETCH + LOAD + `SLOT_CYC` PLAY cycles.
- Start latency: `toggle` at cycle t → FETCH at t+1, LOAD at t+2, PLAY at t+3.
- First `tone_en` high: cycle t+3+`GAP_CYC`+1.
- `tone_en` is low in FETCH, LOAD, PAUSE and IDLE.
- `done` is high for exactly one cycle, coincident with the final PLAY cycle of address `SONG_LEN-1`.
- `paused` and `playing` change in the cycle after the causing pulse.

## Configuration
- `TUNE_SEQ_LOOP_EN` defined:
  - `loop` is sampled on the final PLAY cycle of the last slot;
  - if `loop=1`: `rom_addr` ← 0, → FETCH, `playing` stays 1, `done` still pulses.
- Not defined: the `loop` port exists but is ignored, and the song always ends in IDLE.

## Test plan
All scenarios use `SLOT_CYC=16`, `GAP_CYC=4`, `SONG_LEN=4`, ROM contents = {25, 0, 27, 30}.
- Reset, then `toggle` at cycle 10 → `playing`=1 at 11; `note_out`=25 from 13; `tone_en` rises at 18; `rom_addr`=1 at cycle 29; slot period 18.
- Rest slot (address 1) → `note_out`=0 and `tone_en`=0 for the entire slot; `playing` stays 1.
- Song end, macro undefined (or `loop`=0) → `done` pulses once on the last PLAY cycle of address 3; next cycle IDLE with `rom_addr`=0, `note_out`=0, `playing`=0.
- `TUNE_SEQ_LOOP_EN` defined, `loop`=1 → address sequence 3→0, `done` pulses, `playing` never drops, next `note_out`=25.
- `toggle` at PLAY count 10, hold 50 cycles, then `toggle` → `paused`=1 and `tone_en`=0 throughout; resume finishes the slot after 6 more PLAY cycles; `rom_addr` unchanged while paused.
- `stop` together with `toggle` in PLAY → IDLE, `done`=0. Separately, `toggle` during LOAD → enters PAUSE with counter 0 on the first PLAY cycle.
